// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: command encodings, FSM states,
// datapath width and the default divide-by-zero LO value.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;
  localparam logic [MDU_WIDTH-1:0] MDU_DIV0_LO = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6,
    MDU_RSVD  = 3'd7
  } mdu_cmd_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } mdu_state_e;

  // Two's-complement magnitude of v when neg is set; 0x8000_0000 maps to itself.
  function automatic logic [MDU_WIDTH-1:0] magnitude(input logic [MDU_WIDTH-1:0] v,
                                                     input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// One-bit-per-cycle unsigned multiply (shift-add) / divide (restoring) engine
// built around a 64-bit shift register and a 33-bit adder/subtractor.
module mdu_iter_core
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               step,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic [2*WIDTH-1:0] acc
);

  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [WIDTH-1:0]   addend_q;
  logic               div_q;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     sub_diff;

  // Multiply: acc = {partial, multiplier}, shifting right.
  // Divide:   acc = {remainder, dividend/quotient}, shifting left.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    acc_d    = acc_q;
    add_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, addend_q} : '0);
    rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    sub_diff = rem_sh - {1'b0, addend_q};
    if (div_q) begin
      if (!sub_diff[WIDTH]) acc_d = {sub_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      else                  acc_d = {rem_sh[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b0};
    end else begin
      acc_d = {add_sum, acc_q[WIDTH-1:1]};
    end
  end

  // NOTE: the datapath registers are reset too, so an aborted operation leaves no stale state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      addend_q <= '0;
      div_q    <= 1'b0;
    end else if (start) begin
      acc_q    <= {{WIDTH{1'b0}}, (is_div ? op_a : op_b)};
      addend_q <= is_div ? op_b : op_a;
      div_q    <= is_div;
    end else if (step) begin
      acc_q    <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO and the core stall.
// Optional MDU_EARLY_OUT_EN: multiplies leave CALC once the remaining multiplier bits are zero.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int               WIDTH   = MDU_WIDTH,
  parameter logic [WIDTH-1:0] DIV0_LO = MDU_DIV0_LO
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       mdu,
  input  logic [WIDTH-1:0] rdata1,
  input  logic [WIDTH-1:0] rdata2,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             stall,
  output logic             div_zero
);

  localparam int CNT_W = $clog2(WIDTH);

  mdu_cmd_e   cmd;
  mdu_state_e state_q, state_d;

  logic [CNT_W-1:0]   cnt_q;
  logic               op_div_q;
  logic               neg_res_q;
  logic               neg_rem_q;
  logic               div0_q;
  logic [WIDTH-1:0]   dividend_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic               is_muldiv, is_signed, is_div_cmd;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               accept, step, calc_exit, skip_calc;
  logic [2*WIDTH-1:0] acc, product_raw, product;
  logic [WIDTH-1:0]   quot, rem, res_hi, res_lo;

  assign cmd = mdu_cmd_e'(mdu);

  always_comb begin
    is_muldiv  = cmd inside {MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU};
    is_signed  = (cmd == MDU_MULT) || (cmd == MDU_DIV);
    is_div_cmd = (cmd == MDU_DIV)  || (cmd == MDU_DIVU);
    a_neg      = is_signed & rdata1[WIDTH-1];
    b_neg      = is_signed & rdata2[WIDTH-1];
    a_mag      = magnitude(rdata1, a_neg);
    b_mag      = magnitude(rdata2, b_neg);
  end

`ifdef MDU_EARLY_OUT_EN
  // Shadow of the multiplier bits still to be consumed.
  logic [WIDTH-1:0] mq_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      mq_q <= '0;
    else if (accept) mq_q <= b_mag;
    else if (step)   mq_q <= mq_q >> 1;
  end

  assign skip_calc   = !is_div_cmd && (b_mag == '0);
  assign calc_exit   = (cnt_q == {CNT_W{1'b1}}) || (!op_div_q && ((mq_q >> 1) == '0));
  // After cnt_q+1 steps the product sits above the unconsumed (all-zero) multiplier bits.
  assign product_raw = acc >> ({CNT_W{1'b1}} - cnt_q);
`else
  assign skip_calc   = 1'b0;
  assign calc_exit   = (cnt_q == {CNT_W{1'b1}});
  assign product_raw = acc;
`endif

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    accept  = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_muldiv) begin
          accept  = 1'b1;
          stall   = 1'b1;
          state_d = skip_calc ? SIGN : CALC;
        end
      end
      CALC: begin
        stall = 1'b1;
        step  = 1'b1;
        if (calc_exit) state_d = SIGN;
      end
      SIGN: begin
        stall   = 1'b1;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  mdu_iter_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (accept),
    .step   (step),
    .is_div (is_div_cmd),
    .op_a   (a_mag),
    .op_b   (b_mag),
    .acc    (acc)
  );

  always_comb begin
    product = neg_res_q ? (~product_raw + 1'b1) : product_raw;
    quot    = neg_res_q ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
    rem     = neg_rem_q ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
    res_hi  = product[2*WIDTH-1:WIDTH];
    res_lo  = product[WIDTH-1:0];
    if (op_div_q) begin
      if (div0_q) begin
        res_hi = dividend_q;
        res_lo = DIV0_LO;
      end else begin
        res_hi = rem;
        res_lo = quot;
      end
    end
  end

  // NOTE: state and data registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div0_q     <= 1'b0;
      dividend_q <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q      <= '0;
        op_div_q   <= is_div_cmd;
        neg_res_q  <= a_neg ^ b_neg;
        neg_rem_q  <= a_neg & is_div_cmd;
        div0_q     <= is_div_cmd && (rdata2 == '0);
        dividend_q <= rdata1;
      end else if (step && !calc_exit) begin
        cnt_q <= cnt_q + 1'b1;
      end
      // MTHI/MTLO land only while IDLE; DONE still presents the finished instruction.
      if (state_q == SIGN) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end else if (state_q == IDLE && cmd == MDU_MTHI) begin
        hi_q <= rdata1;
      end else if (state_q == IDLE && cmd == MDU_MTLO) begin
        lo_q <= rdata1;
      end
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = (state_q == DONE) && div0_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl: mul/div results, stall length,
// divide-by-zero, MTHI/MTLO, held command and asynchronous reset abort.
module tb_mdu_ctrl;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  mdu;
  logic [31:0] rdata1, rdata2;
  logic [31:0] hi, lo;
  logic        stall, div_zero;

  int checks   = 0;
  int failures = 0;
  int cyc, dz;

  always #5 clk = ~clk;

  mdu_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mdu      (mdu),
    .rdata1   (rdata1),
    .rdata2   (rdata2),
    .hi       (hi),
    .lo       (lo),
    .stall    (stall),
    .div_zero (div_zero)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected stall length; early-out multiplies stop after the top set multiplier bit.
  function automatic int exp_stall(input logic [2:0] cmd, input logic [31:0] b);
    bit          early = 1'b0;
    logic [31:0] mag;
    int          n = 0;
`ifdef MDU_EARLY_OUT_EN
    early = 1'b1;
`endif
    if (early && (cmd == MDU_MULT || cmd == MDU_MULTU)) begin
      mag = (cmd == MDU_MULT && b[31]) ? (~b + 32'd1) : b;
      for (int i = 0; i < 32; i++) if (mag[i]) n = i + 1;
      return n + 2;
    end
    return 34;
  endfunction

  // Issues a command and holds it until DONE; operands are scrambled after accept.
  task automatic run_op(input logic [2:0] cmd, input logic [31:0] a, input logic [31:0] b,
                        output int cycles, output int dz_cycles);
    mdu = cmd; rdata1 = a; rdata2 = b;
    cycles = 0; dz_cycles = 0;
    #1;
    while (stall && cycles < 100) begin
      cycles++;
      tick();
      rdata1 = ~a;
      rdata2 = b ^ 32'h5A5A_0F0F;
      if (div_zero) dz_cycles++;
    end
  endtask

  initial begin
    rst_n = 1'b1; mdu = MDU_NONE; rdata1 = '0; rdata2 = '0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_stall", stall, 0);
    check("rst_div_zero", div_zero, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("idle_stall", stall, 0);

    // MULT -1 * 2, command held through DONE
    run_op(MDU_MULT, 32'hFFFF_FFFF, 32'd2, cyc, dz);
    check("mult_stall_cycles", cyc, exp_stall(MDU_MULT, 32'd2));
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFE);
    check("mult_no_div_zero", dz, 0);
    tick();
    mdu = MDU_NONE;
    #1;
    check("mult_idle_after_done", stall, 0);
    repeat (3) tick();
    check("mult_single_exec_stall", stall, 0);
    check("mult_single_exec_hi", hi, 32'hFFFF_FFFF);
    check("mult_single_exec_lo", lo, 32'hFFFF_FFFE);

    // MULTU max * max
    run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc, dz);
    check("multu_stall_cycles", cyc, exp_stall(MDU_MULTU, 32'hFFFF_FFFF));
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'h0000_0001);
    tick(); mdu = MDU_NONE;

    // DIV -7 / 2
    run_op(MDU_DIV, 32'hFFFF_FFF9, 32'd2, cyc, dz);
    check("div_stall_cycles", cyc, 34);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);
    check("div_no_div_zero", dz, 0);
    tick(); mdu = MDU_NONE;

    // DIV most-negative / -1
    run_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, cyc, dz);
    check("div_ovf_lo", lo, 32'h8000_0000);
    check("div_ovf_hi", hi, 32'h0000_0000);
    tick(); mdu = MDU_NONE;

    // DIVU 7 / 0 then MTLO in IDLE
    run_op(MDU_DIVU, 32'd7, 32'd0, cyc, dz);
    check("div0_stall_cycles", cyc, 34);
    check("div0_hi", hi, 32'd7);
    check("div0_lo", lo, 32'hFFFF_FFFF);
    check("div0_pulse_in_done", div_zero, 1);
    check("div0_pulse_count", dz, 1);
    tick();
    mdu = MDU_MTLO; rdata1 = 32'h0000_1234;
    #1;
    check("div0_pulse_ended", div_zero, 0);
    check("mtlo_no_stall", stall, 0);
    tick();
    mdu = MDU_NONE;
    check("mtlo_lo", lo, 32'h0000_1234);
    check("mtlo_hi_kept", hi, 32'd7);
    check("mtlo_after_stall", stall, 0);

    // MTHI and reserved command
    mdu = MDU_MTHI; rdata1 = 32'hCAFE_0000;
    #1;
    check("mthi_no_stall", stall, 0);
    tick();
    check("mthi_hi", hi, 32'hCAFE_0000);
    mdu = MDU_RSVD; rdata1 = 32'h1111_2222;
    #1;
    check("rsvd_no_stall", stall, 0);
    tick();
    mdu = MDU_NONE;
    check("rsvd_hi_kept", hi, 32'hCAFE_0000);
    check("rsvd_lo_kept", lo, 32'h0000_1234);

    // Reset at CALC counter 10 aborts immediately
    mdu = MDU_MULTU; rdata1 = 32'hDEAD_BEEF; rdata2 = 32'h0000_1234;
    tick();
    repeat (10) tick();
    check("abort_calc_stall", stall, 1);
    mdu = MDU_NONE;
    rst_n = 1'b0;
    #1;
    check("abort_stall", stall, 0);
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    tick();
    rst_n = 1'b1;
    tick();
    run_op(MDU_MULTU, 32'd3, 32'd5, cyc, dz);
    check("post_rst_stall_cycles", cyc, exp_stall(MDU_MULTU, 32'd5));
    check("post_rst_lo", lo, 32'd15);
    check("post_rst_hi", hi, 32'd0);
    tick(); mdu = MDU_NONE;
    #1;
    check("post_rst_idle", stall, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
